// File: rtl/lathe_cycle_seq.sv
// Auto-cycle sequencer for a retrofitted manual lathe: spin-up, feed, dwell, retract per part, batch counting, manual jog.
// Optional feed/retract watchdog enabled by defining LATHE_FEED_TIMEOUT_EN.
module lathe_cycle_seq #(
   parameter int SPINUP_CYC   = 150_000_000,
   parameter int DWELL_CYC    = 50_000_000,
   parameter int BATCH_SIZE   = 5,
   parameter int FEED_TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       estop,
   input  logic       auto_mode,
   input  logic       jog_fwd,
   input  logic       jog_rev,
   input  logic       limit_home,
   input  logic       limit_end,
   output logic       spindle_on,
   output logic       coolant_on,
   output logic       feed_fwd,
   output logic       feed_rev,
   output logic       busy,
   output logic       batch_done,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [7:0] part_count,
   output logic [2:0] state
);

   localparam int MAX_AB = (SPINUP_CYC > DWELL_CYC) ? SPINUP_CYC : DWELL_CYC;
   localparam int MAX_P  = (MAX_AB > FEED_TIMEOUT) ? MAX_AB : FEED_TIMEOUT;
   localparam int TW     = $clog2(MAX_P) + 1;

   localparam logic [TW-1:0] SPIN_LAST  = TW'(SPINUP_CYC - 1);
   localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYC - 1);
   localparam logic [7:0]    BATCH      = 8'(BATCH_SIZE);
`ifdef LATHE_FEED_TIMEOUT_EN
   localparam logic [TW-1:0] FT_LAST    = TW'(FEED_TIMEOUT - 1);
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SPINUP  = 3'd1,
      FEED    = 3'd2,
      DWELL   = 3'd3,
      RETRACT = 3'd4,
      NEXT    = 3'd5,
      DONE    = 3'd6,
      FAULT   = 3'd7
   } state_t;

   state_t        cur, cur_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [7:0]    part_nxt;
   logic [1:0]    code_nxt;
   logic          stop_pending, stop_nxt;
   logic          start_d;
   logic          start_rise;
   logic          abort;
   logic          conflict;
   logic [7:0]    part_inc;

   assign start_rise = start & ~start_d;
   assign abort      = stop | ~auto_mode;
   assign conflict   = limit_home & limit_end;
   assign part_inc   = part_count + 8'd1;

   // start_d tracks start even during reset so a held button cannot fake an edge.
   always_ff @(posedge clk) begin
      start_d <= start;
      if (rst) begin
         cur          <= IDLE;
         timer        <= '0;
         part_count   <= 8'd0;
         stop_pending <= 1'b0;
         fault_code   <= 2'd0;
      end else begin
         cur          <= cur_nxt;
         timer        <= timer_nxt;
         part_count   <= part_nxt;
         stop_pending <= stop_nxt;
         fault_code   <= code_nxt;
      end
   end

   always_comb begin
      cur_nxt   = cur;
      timer_nxt = timer;
      part_nxt  = part_count;
      stop_nxt  = stop_pending;
      code_nxt  = fault_code;
      if (estop) begin
         cur_nxt   = FAULT;
         code_nxt  = 2'd1;
         timer_nxt = '0;
      end else if (conflict) begin
         cur_nxt   = FAULT;
         code_nxt  = 2'd2;
         timer_nxt = '0;
      end
`ifdef LATHE_FEED_TIMEOUT_EN
      else if (timer == FT_LAST &&
               ((cur == FEED && !limit_end) || (cur == RETRACT && !limit_home))) begin
         cur_nxt   = FAULT;
         code_nxt  = 2'd3;
         timer_nxt = '0;
      end
`endif
      else begin
         case (cur)
            IDLE: begin
               if (auto_mode && start_rise && limit_home) begin
                  cur_nxt   = SPINUP;
                  timer_nxt = '0;
               end
            end
            SPINUP: begin
               timer_nxt = '0;
               if (abort) begin
                  cur_nxt = IDLE;
               end else if (timer == SPIN_LAST) begin
                  cur_nxt = FEED;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            FEED: begin
               if (abort) begin
                  cur_nxt   = RETRACT;
                  stop_nxt  = 1'b1;
                  timer_nxt = '0;
               end else if (limit_end) begin
                  cur_nxt   = DWELL;
                  timer_nxt = '0;
               end else begin
`ifdef LATHE_FEED_TIMEOUT_EN
                  timer_nxt = timer + 1'b1;
`endif
               end
            end
            DWELL: begin
               timer_nxt = '0;
               if (abort) begin
                  cur_nxt  = RETRACT;
                  stop_nxt = 1'b1;
               end else if (timer == DWELL_LAST) begin
                  cur_nxt = RETRACT;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            RETRACT: begin
               // An abort arriving together with home still discards the part.
               if (limit_home) begin
                  timer_nxt = '0;
                  if (stop_pending || abort) begin
                     cur_nxt  = IDLE;
                     stop_nxt = 1'b0;
                  end else begin
                     cur_nxt = NEXT;
                  end
               end else begin
                  if (abort) stop_nxt = 1'b1;
`ifdef LATHE_FEED_TIMEOUT_EN
                  timer_nxt = timer + 1'b1;
`endif
               end
            end
            NEXT: begin
               timer_nxt = '0;
               if (abort) begin
                  cur_nxt = IDLE;
               end else begin
                  part_nxt = part_inc;
                  cur_nxt  = (part_inc == BATCH) ? DONE : FEED;
               end
            end
            DONE: begin
               if (start_rise) begin
                  part_nxt = 8'd0;
                  cur_nxt  = IDLE;
               end
            end
            FAULT: begin
               if (limit_home && !limit_end && start_rise) begin
                  cur_nxt   = IDLE;
                  code_nxt  = 2'd0;
                  timer_nxt = '0;
                  stop_nxt  = 1'b0;
               end
            end
            default: cur_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      spindle_on = 1'b0;
      coolant_on = 1'b0;
      feed_fwd   = 1'b0;
      feed_rev   = 1'b0;
      case (cur)
         IDLE: begin
            if (!auto_mode) begin
               feed_fwd = jog_fwd & ~jog_rev & ~limit_end;
               feed_rev = jog_rev & ~jog_fwd & ~limit_home;
            end
         end
         SPINUP: begin
            spindle_on = 1'b1;
            coolant_on = 1'b1;
         end
         FEED: begin
            spindle_on = 1'b1;
            coolant_on = 1'b1;
            feed_fwd   = 1'b1;
         end
         DWELL: begin
            spindle_on = 1'b1;
            coolant_on = 1'b1;
         end
         RETRACT: begin
            spindle_on = 1'b1;
            feed_rev   = 1'b1;
         end
         NEXT:    spindle_on = 1'b1;
         default: ;
      endcase
      spindle_on = spindle_on & ~estop;
      coolant_on = coolant_on & ~estop;
      feed_fwd   = feed_fwd & ~estop;
      feed_rev   = feed_rev & ~estop;
   end

   assign busy       = (cur >= SPINUP) && (cur <= NEXT);
   assign batch_done = (cur == DONE);
   assign fault      = (cur == FAULT);
   assign state      = cur;

endmodule

// File: tb/tb_lathe_cycle_seq.sv
// Directed bench for lathe_cycle_seq with short timing parameters.
module tb_lathe_cycle_seq;
   logic       clk = 1'b0;
   logic       rst, start, stop, estop, auto_mode, jog_fwd, jog_rev, limit_home, limit_end;
   logic       spindle_on, coolant_on, feed_fwd, feed_rev, busy, batch_done, fault;
   logic [1:0] fault_code;
   logic [7:0] part_count;
   logic [2:0] state;
   int         total = 0;
   int         bad = 0;

   lathe_cycle_seq #(
      .SPINUP_CYC(4), .DWELL_CYC(3), .BATCH_SIZE(2), .FEED_TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .estop(estop),
      .auto_mode(auto_mode), .jog_fwd(jog_fwd), .jog_rev(jog_rev),
      .limit_home(limit_home), .limit_end(limit_end),
      .spindle_on(spindle_on), .coolant_on(coolant_on), .feed_fwd(feed_fwd),
      .feed_rev(feed_rev), .busy(busy), .batch_done(batch_done), .fault(fault),
      .fault_code(fault_code), .part_count(part_count), .state(state)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {spindle, coolant, fwd, rev}
   function automatic logic [3:0] act();
      return {spindle_on, coolant_on, feed_fwd, feed_rev};
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; estop = 1'b0; auto_mode = 1'b1;
      jog_fwd = 1'b0; jog_rev = 1'b0; limit_home = 1'b1; limit_end = 1'b0;
      step(3);
      chk("reset_state", state, 0);
      chk("reset_act", act(), 4'b0000);
      chk("reset_flags", {busy, batch_done, fault, fault_code}, 5'b0);
      chk("reset_parts", part_count, 0);
      rst = 1'b0;
      step(1);
      chk("idle_hold", state, 0);

      // full pass 1
      pulse_start();
      chk("spinup_enter", state, 1);
      chk("spinup_act", act(), 4'b1100);
      chk("spinup_busy", busy, 1);
      step(3);
      chk("spinup_last", state, 1);
      step(1);
      chk("feed_enter", state, 2);
      chk("feed_act", act(), 4'b1110);
      limit_home = 1'b0;
      limit_end = 1'b1;
      step(1);
      chk("dwell_enter", state, 3);
      chk("dwell_act", act(), 4'b1100);
      step(2);
      chk("dwell_last", state, 3);
      step(1);
      chk("retract_enter", state, 4);
      chk("retract_act", act(), 4'b1001);
      limit_end = 1'b0;
      limit_home = 1'b1;
      step(1);
      chk("next_enter", state, 5);
      chk("next_act", act(), 4'b1000);
      chk("next_parts", part_count, 0);
      step(1);
      chk("refeed_state", state, 2);
      chk("parts_1", part_count, 1);

      // pass 2
      limit_home = 1'b0;
      limit_end = 1'b1;
      step(1);
      chk("dwell2", state, 3);
      step(3);
      chk("retract2", state, 4);
      limit_end = 1'b0;
      limit_home = 1'b1;
      step(2);
      chk("done_state", state, 6);
      chk("parts_2", part_count, 2);
      chk("done_flags", {busy, batch_done, fault}, 3'b010);
      chk("done_act", act(), 4'b0000);
      pulse_start();
      chk("done_exit", state, 0);
      chk("parts_clr", part_count, 0);
      step(1);

      // stop during dwell
      pulse_start();
      step(4);
      chk("stop_feed", state, 2);
      limit_home = 1'b0;
      limit_end = 1'b1;
      step(1);
      stop = 1'b1;
      step(1);
      chk("stop_retract", state, 4);
      stop = 1'b0;
      limit_end = 1'b0;
      limit_home = 1'b1;
      step(1);
      chk("stop_idle", state, 0);
      chk("stop_parts", part_count, 0);

      // estop during feed
      pulse_start();
      step(4);
      chk("estop_feed", state, 2);
      limit_home = 1'b0;
      estop = 1'b1;
      #1;
      chk("estop_comb_act", act(), 4'b0000);
      chk("estop_comb_state", state, 2);
      step(1);
      chk("estop_fault", state, 7);
      chk("estop_code", {fault, fault_code}, 3'b101);
      start = 1'b1;
      step(1);
      chk("estop_start_ign", state, 7);
      start = 1'b0;
      estop = 1'b0;
      limit_home = 1'b1;
      step(1);
      chk("fault_no_start", state, 7);
      pulse_start();
      chk("fault_exit", state, 0);
      chk("fault_code_clr", fault_code, 0);
      step(1);

      // switch conflict
      limit_end = 1'b1;
      step(1);
      chk("conflict_state", state, 7);
      chk("conflict_code", fault_code, 2);
      limit_end = 1'b0;
      pulse_start();
      chk("conflict_exit", state, 0);
      step(1);

      // manual jog
      auto_mode = 1'b0;
      jog_fwd = 1'b1;
      #1;
      chk("jog_fwd", act(), 4'b0010);
      jog_rev = 1'b1;
      #1;
      chk("jog_both", act(), 4'b0000);
      jog_fwd = 1'b0;
      #1;
      chk("jog_rev_home", act(), 4'b0000);
      limit_home = 1'b0;
      #1;
      chk("jog_rev", act(), 4'b0001);
      jog_rev = 1'b0;
      auto_mode = 1'b1;
      limit_home = 1'b1;
      step(1);

      // feed watchdog
      pulse_start();
      step(4);
      chk("to_feed", state, 2);
      limit_home = 1'b0;
      step(15);
      chk("to_before", state, 2);
      step(1);
`ifdef LATHE_FEED_TIMEOUT_EN
      chk("to_fault", state, 7);
      chk("to_code", fault_code, 3);
`else
      chk("to_none", state, 2);
      step(20);
      chk("to_still_feed", state, 2);
      chk("to_code_none", fault_code, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
